inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 33 +++
 rtl/inst_loader_fifo.sv | 69 ++++++
 rtl/inst_loader.sv | 165 ++++++++++++++++
 tb/tb_inst_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// ============================================================================
// Module      : inst_loader_pkg
// Description : Shared definitions for the instruction loader: data width,
//               default stream terminator and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_loader_pkg;

  // Instruction word width
  localparam int cXLEN = 32;

  // Default stream terminator; never written into instruction memory
  localparam logic [cXLEN-1:0] cInstEndMarker = 32'hDEABBEAF;

  // Loader sequencing states; DONE and ERR are only left through reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

  // True for the states that end a load and freeze all progress
  function automatic logic is_terminal(input loader_state_t s);
    return (s == DONE) || (s == ERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_loader_fifo.sv
// ============================================================================
// Module      : inst_fifo
// Description : Synchronous FIFO with full/empty flags. The head word is
//               presented combinationally on o_rdata while not empty.
//               A push and a pop in the same cycle leave occupancy unchanged,
//               including when the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fifo #(
  parameter int DEPTH = 4,   // power of two, at least 2
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int cPW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [cPW:0]     r_wr_ptr;
  logic [cPW:0]     r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Flags and qualified push/pop; a full FIFO still takes a word when the
  // head leaves in the same cycle
  always_comb begin
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (r_wr_ptr[cPW] != r_rd_ptr[cPW]) &&
                (r_wr_ptr[cPW-1:0] == r_rd_ptr[cPW-1:0]);
    w_do_pop  = i_pop && !w_empty;
    w_do_push = i_push && (!w_full || w_do_pop);
  end

  // Pointer update; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{cPW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{cPW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[cPW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[cPW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module      : inst_loader
// Description : Streams instruction words into instruction memory through a
//               small input FIFO, stops on an end-marker word, and keeps the
//               core in reset until the load has completed. Overflowing the
//               memory depth is reported as a sticky error.
//               Optional feature macro: INST_LOAD_CHECKSUM_EN adds output
//               loadSum, the XOR of every word written to memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int               pMemDepth  = 1024,
  parameter int               pFifoDepth = 4,
  parameter logic [cXLEN-1:0] pEndMarker = cInstEndMarker
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instWen,
  input  logic [cXLEN-1:0]             inst2Write,
  output logic                         instReady,
  output logic                         memWen,
  output logic [$clog2(pMemDepth)-1:0] memAddr,
  output logic [cXLEN-1:0]             memData,
  output logic [$clog2(pMemDepth):0]   instCount,
  output logic                         loadDone,
  output logic                         loadErr,
  output logic                         coreRst
`ifdef INST_LOAD_CHECKSUM_EN
  ,
  output logic [cXLEN-1:0]             loadSum
`endif
);

  localparam int cAW = $clog2(pMemDepth);
  localparam int cCW = cAW + 1;
  localparam logic [cCW-1:0] cDepthCount = cCW'(pMemDepth);

  loader_state_t r_state;
  loader_state_t w_state_nxt;

  logic             r_memWen;
  logic [cAW-1:0]   r_memAddr;
  logic [cXLEN-1:0] r_memData;
  logic [cCW-1:0]   r_instCount;

  logic             w_accept;
  logic             w_is_marker;
  logic             w_push;
  logic             w_can_pop;
  logic             w_overflow;
  logic             w_write;
  logic [cXLEN-1:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  // Input qualification and write/overflow decisions for this cycle
  always_comb begin
    w_accept    = instWen && instReady;
    w_is_marker = (inst2Write == pEndMarker);
    // The marker only steers the FSM; it never enters the FIFO
    w_push      = w_accept && !w_is_marker;
    w_can_pop   = ((r_state == LOAD) || (r_state == DRAIN)) && !w_fifo_empty;
    // Memory already holds pMemDepth words: the head word cannot be written
    w_overflow  = w_can_pop && (r_instCount == cDepthCount);
    w_write     = w_can_pop && !w_overflow;
  end

  inst_fifo #(
    .DEPTH (pFifoDepth),
    .WIDTH (cXLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (inst2Write),
    .i_pop   (w_write),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    instReady   = 1'b0;
    loadDone    = 1'b0;
    loadErr     = 1'b0;
    coreRst     = 1'b1;

    unique case (r_state)
      IDLE: begin
        instReady = !w_fifo_full;
        if (w_accept) w_state_nxt = w_is_marker ? DRAIN : LOAD;
      end
      LOAD: begin
        instReady = !w_fifo_full;
        if (w_overflow)                   w_state_nxt = ERR;
        else if (w_accept && w_is_marker) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leaves one cycle after the final pop, so the last memWen is
        // already visible when loadDone rises
        if (w_overflow)        w_state_nxt = ERR;
        else if (w_fifo_empty) w_state_nxt = DONE;
      end
      DONE: begin
        loadDone = 1'b1;
        coreRst  = 1'b0;
      end
      ERR: begin
        loadErr = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered memory write port; address follows the running word count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memWen    <= 1'b0;
      r_memAddr   <= '0;
      r_memData   <= '0;
      r_instCount <= '0;
    end else begin
      r_memWen <= w_write;
      if (w_write) begin
        r_memAddr   <= r_instCount[cAW-1:0];
        r_memData   <= w_fifo_rdata;
        r_instCount <= r_instCount + {{cAW{1'b0}}, 1'b1};
      end
    end
  end

  assign memWen    = r_memWen;
  assign memAddr   = r_memAddr;
  assign memData   = r_memData;
  assign instCount = r_instCount;

`ifdef INST_LOAD_CHECKSUM_EN
  logic [cXLEN-1:0] r_loadSum;

  // Running XOR of written words, frozen once the load has ended
  always_ff @(posedge clk) begin
    if (rst)                                 r_loadSum <= '0;
    else if (w_write && !is_terminal(r_state)) r_loadSum <= r_loadSum ^ w_fifo_rdata;
  end

  assign loadSum = r_loadSum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module      : tb_inst_loader
// Description : Self-checking bench for inst_loader (depth 8 and depth 4096
//               instances) and its inst_fifo. Optional macro
//               INST_LOAD_CHECKSUM_EN enables the loadSum checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

  localparam logic [31:0] MARK = 32'hDEABBEAF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: 8-word memory
  logic        s_wen = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_instReady, s_memWen, s_loadDone, s_loadErr, s_coreRst;
  logic [2:0]  s_memAddr;
  logic [31:0] s_memData;
  logic [3:0]  s_instCount;

  // Large instance: 4096-word memory
  logic        b_wen = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_instReady, b_memWen, b_loadDone, b_loadErr, b_coreRst;
  logic [11:0] b_memAddr;
  logic [31:0] b_memData;
  logic [12:0] b_instCount;

`ifdef INST_LOAD_CHECKSUM_EN
  logic [31:0] s_loadSum, b_loadSum;
`endif

  // Standalone FIFO
  logic        f_push = 1'b0, f_pop = 1'b0;
  logic [31:0] f_wdata = '0, f_rdata;
  logic        f_full, f_empty;

  inst_loader #(.pMemDepth(8), .pFifoDepth(4), .pEndMarker(MARK)) dut_s (
    .clk(clk), .rst(rst), .instWen(s_wen), .inst2Write(s_data),
    .instReady(s_instReady), .memWen(s_memWen), .memAddr(s_memAddr),
    .memData(s_memData), .instCount(s_instCount), .loadDone(s_loadDone),
    .loadErr(s_loadErr), .coreRst(s_coreRst)
`ifdef INST_LOAD_CHECKSUM_EN
    , .loadSum(s_loadSum)
`endif
  );

  inst_loader #(.pMemDepth(4096), .pFifoDepth(4), .pEndMarker(MARK)) dut_b (
    .clk(clk), .rst(rst), .instWen(b_wen), .inst2Write(b_data),
    .instReady(b_instReady), .memWen(b_memWen), .memAddr(b_memAddr),
    .memData(b_memData), .instCount(b_instCount), .loadDone(b_loadDone),
    .loadErr(b_loadErr), .coreRst(b_coreRst)
`ifdef INST_LOAD_CHECKSUM_EN
    , .loadSum(b_loadSum)
`endif
  );

  inst_fifo #(.DEPTH(4), .WIDTH(32)) dut_f (
    .clk(clk), .rst(rst), .i_push(f_push), .i_wdata(f_wdata), .i_pop(f_pop),
    .o_rdata(f_rdata), .o_full(f_full), .o_empty(f_empty)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected {address, data} per instance
  typedef struct packed { logic [11:0] addr; logic [31:0] data; } exp_t;
  exp_t q_s[$];
  exp_t q_b[$];
  int   nxt_s = 0;
  int   nxt_b = 0;

  // Monitor-owned statistics
  int wr_s = 0, wr_b = 0, cyc = 0, prev_b = -10, gaps_b = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (s_memWen) begin
      wr_s++;
      if (q_s.size() == 0) check("s_extra_write_addr", 64'(s_memAddr), 64'hFFFF);
      else begin
        e = q_s.pop_front();
        check("s_addr", 64'(s_memAddr), 64'(e.addr));
        check("s_data", 64'(s_memData), 64'(e.data));
      end
      check("s_done_at_write", 64'(s_loadDone), 64'(1'b0));
    end
    if (b_memWen) begin
      wr_b++;
      if (cyc != prev_b + 1) gaps_b++;
      prev_b = cyc;
      if (q_b.size() == 0) check("b_extra_write_addr", 64'(b_memAddr), 64'hFFFF);
      else begin
        e = q_b.pop_front();
        check("b_addr", 64'(b_memAddr), 64'(e.addr));
        check("b_data", 64'(b_memData), 64'(e.data));
      end
      check("b_done_at_write", 64'(b_loadDone), 64'(1'b0));
    end
  end

  function automatic logic ready_of(input int which);
    return (which == 0) ? s_instReady : b_instReady;
  endfunction

  task automatic push_exp(input int which, input logic [31:0] d);
    if (which == 0) begin q_s.push_back({12'(nxt_s), d}); nxt_s++; end
    else            begin q_b.push_back({12'(nxt_b), d}); nxt_b++; end
  endtask

  task automatic idle();
    s_wen = 1'b0;
    b_wen = 1'b0;
  endtask

  // Present a word and hold it until the loader takes it (called at negedge)
  task automatic send(input int which, input logic [31:0] d, input bit exp_wr);
    int t;
    t = 0;
    if (which == 0) begin s_wen = 1'b1; s_data = d; end
    else            begin b_wen = 1'b1; b_data = d; end
    while (!ready_of(which) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ready_timeout", 64'(ready_of(which)), 64'(1'b1));
    else if (exp_wr) push_exp(which, d);
    @(negedge clk);
  endtask

  task automatic wait_end(input int which, input int bound);
    int t;
    t = 0;
    while (t < bound && !((which == 0) ? (s_loadDone || s_loadErr)
                                       : (b_loadDone || b_loadErr))) begin
      @(negedge clk); t++;
    end
    if (t >= bound)
      check("end_timeout", 64'((which == 0) ? s_loadDone : b_loadDone), 64'(1'b1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q_s.delete(); q_b.delete();
    nxt_s = 0; nxt_b = 0;
  endtask

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int w0, g0;
    logic [31:0] w, xs;
    logic [31:0] fm[$];
    logic [31:0] head;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_memWen",    64'(s_memWen),    64'(1'b0));
    check("rst_memAddr",   64'(s_memAddr),   64'(0));
    check("rst_memData",   64'(s_memData),   64'(0));
    check("rst_instCount", 64'(s_instCount), 64'(0));
    check("rst_loadDone",  64'(s_loadDone),  64'(1'b0));
    check("rst_loadErr",   64'(s_loadErr),   64'(1'b0));
    check("rst_coreRst",   64'(s_coreRst),   64'(1'b1));
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(s_instReady), 64'(1'b1));

    // ---------------- two-word load ----------------
    w0 = wr_s;
    send(0, 32'h0000_0013, 1'b1);
    send(0, 32'h0050_0093, 1'b1);
    send(0, MARK, 1'b0);
    idle();
    wait_end(0, 20);
    check("basic_instCount", 64'(s_instCount), 64'(2));
    check("basic_loadDone",  64'(s_loadDone),  64'(1'b1));
    check("basic_coreRst",   64'(s_coreRst),   64'(1'b0));
    check("basic_writes",    64'(wr_s - w0),   64'(2));
    check("basic_queue",     64'(q_s.size()),  64'(0));

    // Strobes in DONE are ignored
    check("done_ready", 64'(s_instReady), 64'(1'b0));
    s_wen = 1'b1; s_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    idle();
    check("done_hold_count", 64'(s_instCount), 64'(2));
    check("done_no_write",   64'(wr_s - w0),   64'(2));
    check("done_hold_done",  64'(s_loadDone),  64'(1'b1));

    // ---------------- marker straight out of IDLE ----------------
    do_reset();
    send(0, MARK, 1'b0);
    idle();
    wait_end(0, 20);
    check("mark_idle_count", 64'(s_instCount), 64'(0));
    check("mark_idle_done",  64'(s_loadDone),  64'(1'b1));
    check("mark_idle_crst",  64'(s_coreRst),   64'(1'b0));

    // ---------------- overflow: 9 words into 8 ----------------
    do_reset();
    w0 = wr_s;
    for (int i = 0; i < 9; i++) send(0, 32'h0000_1000 + 32'(i), (i < 8));
    send(0, MARK, 1'b0);
    idle();
    wait_end(0, 20);
    repeat (2) @(negedge clk);
    check("ovf_loadErr",   64'(s_loadErr),   64'(1'b1));
    check("ovf_coreRst",   64'(s_coreRst),   64'(1'b1));
    check("ovf_loadDone",  64'(s_loadDone),  64'(1'b0));
    check("ovf_instCount", 64'(s_instCount), 64'(8));
    check("ovf_writes",    64'(wr_s - w0),   64'(8));
    check("ovf_queue",     64'(q_s.size()),  64'(0));
    check("ovf_ready",     64'(s_instReady), 64'(1'b0));

    // ---------------- FIFO full behaviour ----------------
    check("fifo_empty0", 64'(f_empty), 64'(1'b1));
    check("fifo_full0",  64'(f_full),  64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      f_push = 1'b1; f_wdata = 32'hA000_0000 + 32'(i); fm.push_back(f_wdata);
      @(negedge clk);
    end
    f_push = 1'b0;
    check("fifo_full4", 64'(f_full),  64'(1'b1));
    check("fifo_nempty", 64'(f_empty), 64'(1'b0));
    // Push while full is dropped
    f_push = 1'b1; f_wdata = 32'hBAD0_0000;
    @(negedge clk);
    f_push = 1'b0;
    check("fifo_drop_full", 64'(f_full), 64'(1'b1));
    // Push and pop together while full
    head = fm.pop_front();
    check("fifo_head", 64'(f_rdata), 64'(head));
    f_push = 1'b1; f_pop = 1'b1; f_wdata = 32'hC0DE_0005; fm.push_back(f_wdata);
    @(negedge clk);
    f_push = 1'b0; f_pop = 1'b0;
    check("fifo_pushpop_full", 64'(f_full), 64'(1'b1));
    for (int i = 0; i < 4; i++) begin
      head = fm.pop_front();
      check("fifo_order", 64'(f_rdata), 64'(head));
      f_pop = 1'b1;
      @(negedge clk);
    end
    f_pop = 1'b0;
    check("fifo_empty_end", 64'(f_empty), 64'(1'b1));

    // ---------------- reset mid-load ----------------
    do_reset();
    w0 = wr_s;
    for (int i = 0; i < 5; i++) send(0, 32'h0000_2000 + 32'(i), 1'b1);
    rst = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_write", 64'(s_memWen), 64'(1'b0));
    end
    // Words 0..3 reached memory before the reset edge; word 4 is discarded
    check("midrst_writes", 64'(wr_s - w0), 64'(4));
    rst = 1'b0;
    q_s.delete(); nxt_s = 0;
    @(negedge clk);
    check("midrst_count0", 64'(s_instCount), 64'(0));
    check("midrst_data0",  64'(s_memData),   64'(0));
    w0 = wr_s;
    for (int i = 0; i < 3; i++) send(0, 32'h0000_3000 + 32'(i), 1'b1);
    send(0, MARK, 1'b0);
    idle();
    wait_end(0, 20);
    check("reload_count", 64'(s_instCount), 64'(3));
    check("reload_writes", 64'(wr_s - w0),  64'(3));
    check("reload_done",  64'(s_loadDone),  64'(1'b1));
    check("reload_queue", 64'(q_s.size()),  64'(0));

    // ---------------- 2000-word stream ----------------
    do_reset();
    w0 = wr_b; g0 = gaps_b; xs = '0;
    for (int i = 0; i < 2000; i++) begin
      w = $urandom();
      if (w == MARK) w = w ^ 32'h1;
      xs = xs ^ w;
      send(1, w, 1'b1);
    end
    send(1, MARK, 1'b0);
    idle();
    wait_end(1, 50);
    check("stream_count",  64'(b_instCount), 64'(2000));
    check("stream_writes", 64'(wr_b - w0),   64'(2000));
    check("stream_gaps",   64'(gaps_b - g0), 64'(1));
    check("stream_queue",  64'(q_b.size()),  64'(0));
    check("stream_done",   64'(b_loadDone),  64'(1'b1));
    check("stream_err",    64'(b_loadErr),   64'(1'b0));
`ifdef INST_LOAD_CHECKSUM_EN
    check("stream_sum",    64'(b_loadSum),   64'(xs));

    // ---------------- checksum of two words ----------------
    do_reset();
    check("sum_reset", 64'(b_loadSum), 64'(0));
    send(1, 32'hFFFF_0000, 1'b1);
    send(1, 32'h0000_FFFF, 1'b1);
    send(1, MARK, 1'b0);
    idle();
    wait_end(1, 20);
    check("sum_value", 64'(b_loadSum), 64'hFFFF_FFFF);
    b_wen = 1'b1; b_data = 32'h0F0F_0F0F;
    repeat (3) @(negedge clk);
    idle();
    check("sum_frozen", 64'(b_loadSum), 64'hFFFF_FFFF);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_s", 64'(q_s.size()), 64'(0));
    check("final_queue_b", 64'(q_b.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
